serial_seq_tx: RTL and testbench

SERIAL_SEQ_TX -- requirements
Module: serial_seq_tx

---
 rtl/serial_seq_tx.sv | 172 +++++++++++++++++
 tb/tb_serial_seq_tx.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_seq_tx.sv
// serial_seq_tx -- frames a parallel word into a serial bit stream.
//
// Each frame is an optional 4-bit sync header, then WIDTH payload bits.
// Both go out MSB-first. A forced idle gap of GAP_CYCLES cycles follows.
// A new word is accepted only while the block is idle.
//
// Build option: define SYNC_HEADER_EN to send SYNC_PATTERN ahead of each
// payload. Without it, frames carry the payload only.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous, active-low reset
//   din         payload word
//   din_valid   din holds a word to send
//   din_ready   block can accept a word this cycle (high only in IDLE)
//   q           serial bit stream (registered)
//   q_valid     q carries a header or payload bit (registered)
//   frame_done  pulse on the last payload bit of a frame (registered)
//   frame_cnt   completed frames, wraps 255 -> 0
//
// state | meaning
// IDLE  | waiting for din_valid; din_ready high
// SYNC  | shifting out the sync header (SYNC_HEADER_EN only)
// DATA  | shifting out the captured payload word
// GAP   | forced idle cycles after a frame
module serial_seq_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter logic [3:0]  SYNC_PATTERN = 4'b1001,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             q,
  output logic             q_valid,
  output logic             frame_done,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned HDR_LEN = $bits(SYNC_PATTERN);
  localparam int unsigned BIT_MAX = (WIDTH > HDR_LEN) ? WIDTH : HDR_LEN;
  localparam int unsigned BIT_W   = $clog2(BIT_MAX);
  localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);

  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
`ifdef SYNC_HEADER_EN
  localparam logic [BIT_W-1:0] SYNC_LAST = BIT_W'(HDR_LEN - 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef SYNC_HEADER_EN
    SYNC = 2'd1,
`endif
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    shift_d      = shift_q;
    q_d          = 1'b0;
    q_valid_d    = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (din_valid) begin
          shift_d   = din;
          bit_cnt_d = '0;
`ifdef SYNC_HEADER_EN
          state_d   = SYNC;
`else
          state_d   = DATA;
`endif
        end
      end
`ifdef SYNC_HEADER_EN
      SYNC: begin
        if (bit_cnt_q == SYNC_LAST) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
`endif
      DATA: begin
        if (bit_cnt_q == DATA_LAST) begin
          state_d   = GAP;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state and
    // counters of the coming cycle; this puts the first bit on q in the
    // cycle right after acceptance.
    case (state_d)
`ifdef SYNC_HEADER_EN
      SYNC: begin
        q_d       = SYNC_PATTERN[2'(SYNC_LAST - bit_cnt_d)];
        q_valid_d = 1'b1;
      end
`endif
      DATA: begin
        q_d          = shift_d[WIDTH-1];
        q_valid_d    = 1'b1;
        frame_done_d = (bit_cnt_d == DATA_LAST);
      end
      default: ;
    endcase

    frame_cnt_d = frame_cnt_q + 8'(frame_done_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      shift_q      <= '0;
      q_q          <= 1'b0;
      q_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      shift_q      <= shift_d;
      q_q          <= q_d;
      q_valid_q    <= q_valid_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign din_ready  = (state_q == IDLE);
  assign q          = q_q;
  assign q_valid    = q_valid_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_serial_seq_tx.sv
// Bench for serial_seq_tx. Header length follows SYNC_HEADER_EN so the same
// bench serves both builds.
module tb_serial_seq_tx;

  localparam int W   = 8;
  localparam int GAP = 2;
`ifdef SYNC_HEADER_EN
  localparam int HDR = 4;
`else
  localparam int HDR = 0;
`endif
  localparam int FB   = HDR + W;        // serial bits per frame
  localparam int P    = FB + GAP + 1;   // frame period incl. acceptance cycle
  localparam int MAXN = 256;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, q, q_valid, frame_done;
  logic [7:0]   frame_cnt;

  int errors = 0;
  int checks = 0;
  int fc_base = 0;
  int model_frames;

  logic [W-1:0] stim_din [MAXN];
  logic         stim_v   [MAXN];
  logic         obs_q [MAXN], obs_v [MAXN], obs_fd [MAXN], obs_rdy [MAXN];
  logic [7:0]   obs_fc [MAXN];
  logic         exp_q [MAXN+P], exp_v [MAXN+P], exp_fd [MAXN+P], exp_rdy [MAXN+P];
  logic [7:0]   exp_fc [MAXN+P];

  serial_seq_tx #(.WIDTH(W), .SYNC_PATTERN(4'b1001), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .q(q), .q_valid(q_valid),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // k-th serial bit of a frame carrying word w: header first, then payload.
  function automatic logic frame_bit(logic [W-1:0] w, int k);
    logic [3:0] pat;
    pat = 4'b1001;
    if (k < HDR) return pat[3-k];
    return w[W-1-(k-HDR)];
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < MAXN; i++) begin
      stim_v[i]   = 1'b0;
      stim_din[i] = W'($urandom());
    end
  endtask

  // Timeline model: a word offered while the block is free starts a frame;
  // bits follow on the next FB cycles, then GAP idle cycles, then free again.
  task automatic build_model(input int n);
    int free_at;
    int running;
    free_at = 0;
    model_frames = 0;
    for (int i = 0; i < MAXN + P; i++) begin
      exp_q[i] = 1'b0; exp_v[i] = 1'b0; exp_fd[i] = 1'b0; exp_rdy[i] = 1'b0;
      exp_fc[i] = '0;
    end
    for (int i = 0; i <= n; i++) begin
      exp_rdy[i] = (i >= free_at);
      if (i >= free_at && stim_v[i]) begin
        for (int k = 0; k < FB; k++) begin
          exp_q[i+1+k] = frame_bit(stim_din[i], k);
          exp_v[i+1+k] = 1'b1;
        end
        exp_fd[i+FB] = 1'b1;
        free_at = i + P;
        model_frames++;
      end
    end
    running = fc_base;
    for (int c = 0; c <= n; c++) begin
      exp_fc[c] = 8'(running);
      if (exp_fd[c]) running++;
    end
  endtask

  // Plays stim[0..n] (stim[i] is seen by the edge closing cycle i) and
  // records outputs sampled mid-cycle for cycles 1..n, then drains.
  task automatic run(input int n);
    stim_v[n] = 1'b0;
    build_model(n);
    @(negedge clk);
    din = stim_din[0]; din_valid = stim_v[0];
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      obs_q[i] = q; obs_v[i] = q_valid; obs_fd[i] = frame_done;
      obs_rdy[i] = din_ready; obs_fc[i] = frame_cnt;
      din = stim_din[i]; din_valid = stim_v[i];
    end
    din_valid = 1'b0;
    repeat (P + 2) @(negedge clk);
    fc_base = (fc_base + model_frames) % 256;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    din_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({q, q_valid, frame_done} !== 3'b000 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs q/v/fd=%b%b%b cnt=%0d expected 000 cnt=0",
               q, q_valid, frame_done, frame_cnt);
    end
    din_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b expected 1", din_ready);
    end
    fc_base = 0;
  endtask

  task automatic test_single(input logic [W-1:0] w);
    int n, first;
    n = P + 4;
    clear_stim();
    stim_v[0] = 1'b1; stim_din[0] = w;
    run(n);
    for (int i = 1; i <= n; i++) begin
      checks++;
      if ({obs_q[i], obs_v[i], obs_fd[i], obs_rdy[i]} !== {exp_q[i], exp_v[i], exp_fd[i], exp_rdy[i]}) begin
        errors++;
        $display("FAIL single_%h cycle %0d q/v/fd/rdy got %b%b%b%b expected %b%b%b%b", w, i,
                 obs_q[i], obs_v[i], obs_fd[i], obs_rdy[i], exp_q[i], exp_v[i], exp_fd[i], exp_rdy[i]);
      end
      if (!exp_fd[i]) begin
        checks++;
        if (obs_fc[i] !== exp_fc[i]) begin
          errors++;
          $display("FAIL single_cnt cycle %0d got %0d expected %0d", i, obs_fc[i], exp_fc[i]);
        end
      end
    end
    first = 0;
    for (int i = 1; i <= n; i++) if (first == 0 && obs_rdy[i]) first = i;
    checks++;
    if (first != ((HDR == 4) ? 15 : 11)) begin
      errors++;
      $display("FAIL single_period got %0d expected %0d", first, (HDR == 4) ? 15 : 11);
    end
  endtask

  task automatic test_back_to_back();
    int n, nfd;
    n = 3 * P;
    clear_stim();
    for (int i = 0; i < 2 * P; i++) begin
      stim_v[i] = 1'b1;
      stim_din[i] = (i < P) ? 8'hFF : 8'h00;
    end
    run(n);
    nfd = 0;
    for (int i = 1; i <= n; i++) begin
      if (obs_fd[i]) nfd++;
      checks++;
      if ({obs_q[i], obs_v[i], obs_fd[i], obs_rdy[i]} !== {exp_q[i], exp_v[i], exp_fd[i], exp_rdy[i]}) begin
        errors++;
        $display("FAIL b2b cycle %0d q/v/fd/rdy got %b%b%b%b expected %b%b%b%b", i,
                 obs_q[i], obs_v[i], obs_fd[i], obs_rdy[i], exp_q[i], exp_v[i], exp_fd[i], exp_rdy[i]);
      end
      if (!exp_fd[i]) begin
        checks++;
        if (obs_fc[i] !== exp_fc[i]) begin
          errors++;
          $display("FAIL b2b_cnt cycle %0d got %0d expected %0d", i, obs_fc[i], exp_fc[i]);
        end
      end
    end
    checks++;
    if (nfd != 2) begin
      errors++;
      $display("FAIL b2b_frames got %0d expected 2", nfd);
    end
  endtask

  task automatic test_din_change();
    int n, nfd;
    n = P + 6;
    clear_stim();
    stim_v[0] = 1'b1;
    stim_v[HDR + 3] = 1'b1;
    stim_din[HDR + 3] = ~stim_din[0];
    run(n);
    nfd = 0;
    for (int i = 1; i <= n; i++) begin
      if (obs_fd[i]) nfd++;
      checks++;
      if ({obs_q[i], obs_v[i], obs_fd[i], obs_rdy[i]} !== {exp_q[i], exp_v[i], exp_fd[i], exp_rdy[i]}) begin
        errors++;
        $display("FAIL din_change cycle %0d q/v/fd/rdy got %b%b%b%b expected %b%b%b%b", i,
                 obs_q[i], obs_v[i], obs_fd[i], obs_rdy[i], exp_q[i], exp_v[i], exp_fd[i], exp_rdy[i]);
      end
    end
    checks++;
    if (nfd != 1) begin
      errors++;
      $display("FAIL din_change_frames got %0d expected 1", nfd);
    end
    checks++;
    if (frame_cnt !== 8'(fc_base)) begin
      errors++;
      $display("FAIL din_change_cnt got %0d expected %0d", frame_cnt, fc_base);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] w;
    w = W'($urandom());
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    fc_base = 0;
    @(negedge clk);
    din = w; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (HDR + 2) @(negedge clk);
    checks++;
    if (q_valid !== 1'b1 || q !== frame_bit(w, HDR + 2)) begin
      errors++;
      $display("FAIL mid_before q/v got %b%b expected %b1", q, q_valid, frame_bit(w, HDR + 2));
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({q, q_valid, frame_done} !== 3'b000 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_abort q/v/fd=%b%b%b cnt=%0d expected 000 cnt=0",
               q, q_valid, frame_done, frame_cnt);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b1 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_release rdy=%b cnt=%0d expected rdy=1 cnt=0", din_ready, frame_cnt);
    end
    test_single(W'($urandom()));
  endtask

  task automatic test_random();
    int n;
    n = MAXN - 1;
    clear_stim();
    for (int i = 0; i < n; i++) stim_v[i] = ($urandom_range(0, 2) == 0);
    run(n);
    for (int i = 1; i <= n; i++) begin
      checks++;
      if ({obs_q[i], obs_v[i], obs_fd[i], obs_rdy[i]} !== {exp_q[i], exp_v[i], exp_fd[i], exp_rdy[i]}) begin
        errors++;
        $display("FAIL random cycle %0d q/v/fd/rdy got %b%b%b%b expected %b%b%b%b", i,
                 obs_q[i], obs_v[i], obs_fd[i], obs_rdy[i], exp_q[i], exp_v[i], exp_fd[i], exp_rdy[i]);
      end
      if (!exp_fd[i]) begin
        checks++;
        if (obs_fc[i] !== exp_fc[i]) begin
          errors++;
          $display("FAIL random_cnt cycle %0d got %0d expected %0d", i, obs_fc[i], exp_fc[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int cnt;
    logic prev_fd, done;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    fc_base = 0;
    cnt = 0; prev_fd = 1'b0; done = 1'b0;
    din_valid = 1'b1;
    for (int c = 0; c < 256 * P + 20 && !done; c++) begin
      @(negedge clk);
      din = W'($urandom());
      if (prev_fd && cnt == 255) begin
        checks++;
        if (frame_cnt !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255 got %0d expected 255", frame_cnt);
        end
      end
      if (prev_fd && cnt == 256) begin
        checks++;
        if (frame_cnt !== 8'd0) begin
          errors++;
          $display("FAIL wrap_0 got %0d expected 0", frame_cnt);
        end
        done = 1'b1;
        din_valid = 1'b0;
      end
      if (frame_done) cnt++;
      prev_fd = frame_done;
    end
    din_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wrap_timeout frames seen %0d expected 256", cnt);
    end
    repeat (P + 2) @(negedge clk);
    fc_base = 0;
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    test_single(8'h3C);
    test_back_to_back();
    test_din_change();
    test_reset_mid_frame();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
